// File: rtl/ibniz_scan_driver_pkg.sv
// Shared definitions for the Ibniz scan driver: FSM states, Q16.16 constants
// and the layout of the pixel tag that travels alongside the generator.
package ibniz_scan_driver_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SCAN      = 2'd1,
        DRAIN     = 2'd2,
        FRAME_END = 2'd3
    } state_t;

    localparam logic [31:0] Q16_ONE       = 32'h0001_0000;
    localparam logic [31:0] Q16_MINUS_ONE = 32'hFFFF_0000;

    // Tag layout: {valid, col[11:0], row[11:0], last}
    localparam int TAG_W = 1 + 12 + 12 + 1;

    function automatic logic [TAG_W-1:0] pack_tag(input logic        valid,
                                                  input logic [11:0] col,
                                                  input logic [11:0] row,
                                                  input logic        last);
        return {valid, col, row, last};
    endfunction

endpackage

// File: rtl/ibniz_scan_driver_tag_delay.sv
// Shift register of DEPTH stages, W bits wide, with shift enable and
// synchronous clear. Keeps pixel tags in step with the generator pipeline.
module ibniz_tag_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stages [DEPTH];

    // Shift one stage per enabled cycle; clear every stage on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else if (en) begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/ibniz_scan_driver.sv
// Ibniz scan driver: raster-scans a frame in Q16.16 coordinates, feeds an
// Ibniz generator, and re-associates its results with pixel positions for a
// valid/ready pixel stream. Backpressure freezes the whole pipeline via ena.
// Optional feature: define IBNIZ_SCAN_PAUSE_EN to add a pause input that
// holds the time base at the end of each frame.
module ibniz_scan_driver
    import ibniz_scan_driver_pkg::*;
#(
    parameter int          H_RES  = 256,
    parameter int          V_RES  = 192,
    parameter int          LAT    = 1,
    parameter logic [31:0] T_STEP = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cont,
`ifdef IBNIZ_SCAN_PAUSE_EN
    input  logic        pause,
`endif
    output logic        ena_out,
    output logic [31:0] T_out,
    output logic [31:0] X_out,
    output logic [31:0] Y_out,
    input  logic [31:0] V_in,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [31:0] pix_data,
    output logic [11:0] pix_col,
    output logic [11:0] pix_row,
    output logic        pix_last,
    output logic        frame_done,
    output logic        busy
);

    localparam logic [31:0] XSTEP   = 32'h0002_0000 / H_RES;
    localparam logic [31:0] YSTEP   = 32'h0002_0000 / V_RES;
    localparam logic [11:0] COL_MAX = 12'(H_RES - 1);
    localparam logic [11:0] ROW_MAX = 12'(V_RES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [11:0]        col;
    logic [11:0]        row;
    logic               adv;
    logic               at_last;
    logic               t_advance;
    logic [TAG_W-1:0]   tag_in;
    logic [TAG_W-1:0]   tag_out;

    assign adv     = ~pix_valid | pix_ready;
    assign ena_out = adv;
    assign at_last = (col == COL_MAX) && (row == ROW_MAX);

`ifdef IBNIZ_SCAN_PAUSE_EN
    assign t_advance = ~pause;
`else
    assign t_advance = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and tag injection; only SCAN issues valid tags.
    always_comb begin
        state_nxt = state;
        tag_in    = '0;
        case (state)
            IDLE: begin
                if (adv && start) state_nxt = SCAN;
            end
            SCAN: begin
                tag_in = pack_tag(1'b1, col, row, at_last);
                if (adv && at_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pix_valid && pix_ready && pix_last) state_nxt = FRAME_END;
            end
            FRAME_END: begin
                state_nxt = cont ? SCAN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Incremental coordinate generation and per-frame time base update.
    always_ff @(posedge clk) begin
        if (rst) begin
            col   <= '0;
            row   <= '0;
            X_out <= Q16_MINUS_ONE;
            Y_out <= Q16_MINUS_ONE;
            T_out <= '0;
        end else begin
            if (adv && state == SCAN) begin
                if (col == COL_MAX) begin
                    col   <= '0;
                    X_out <= Q16_MINUS_ONE;
                    if (row == ROW_MAX) begin
                        row   <= '0;
                        Y_out <= Q16_MINUS_ONE;
                    end else begin
                        row   <= row + 12'd1;
                        Y_out <= Y_out + YSTEP;
                    end
                end else begin
                    col   <= col + 12'd1;
                    X_out <= X_out + XSTEP;
                end
            end
            if (state == FRAME_END && t_advance) begin
                T_out <= T_out + T_STEP;
            end
        end
    end

    ibniz_tag_delay #(
        .DEPTH(LAT),
        .W    (TAG_W)
    ) u_tag_delay (
        .clk(clk),
        .rst(rst),
        .en (adv),
        .d  (tag_in),
        .q  (tag_out)
    );

    // Output stage: pair the generator result with its delayed tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_col   <= '0;
            pix_row   <= '0;
            pix_last  <= 1'b0;
        end else if (adv) begin
            pix_valid <= tag_out[25];
            pix_data  <= V_in;
            pix_col   <= tag_out[24:13];
            pix_row   <= tag_out[12:1];
            pix_last  <= tag_out[0];
        end
    end

    assign frame_done = (state == FRAME_END);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ibniz_scan_driver.sv
// Self-checking bench for ibniz_scan_driver on a 4x2 frame with a 25-deep
// echo generator (V = X^Y). Expected pixels go into a scoreboard queue when a
// scan is started; an independent monitor pops and compares on every accept.
module tb_ibniz_scan_driver;

    localparam int H_RES = 4;
    localparam int V_RES = 2;
    localparam int LAT   = 25;

    typedef struct {
        logic [31:0] data;
        logic [11:0] col;
        logic [11:0] row;
        logic        last;
        logic        first;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        pause = 1'b0;
    logic        ena_out;
    logic [31:0] T_out, X_out, Y_out, V_in;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [31:0] pix_data;
    logic [11:0] pix_col, pix_row;
    logic        pix_last, frame_done, busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    pix_t        sb[$];
    logic [31:0] gen_pipe [LAT];
    bit          rand_mode = 0;
    bit          mon_en = 0;
    bit          first_check = 0;
    int          exp_first_cyc = 0;
    int          last_acc_cyc = -10;
    int          last_final_cyc = -10;

    // Hand-computed X^Y for the 4x2 raster, row-major.
    logic [31:0] exp_data [8] = '{32'h0000_0000, 32'h0000_8000, 32'hFFFF_0000, 32'hFFFF_8000,
                                  32'hFFFF_0000, 32'hFFFF_8000, 32'h0000_0000, 32'h0000_8000};

    ibniz_scan_driver #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .LAT   (LAT),
        .T_STEP(32'h0000_0400)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
`ifdef IBNIZ_SCAN_PAUSE_EN
        .pause     (pause),
`endif
        .ena_out   (ena_out),
        .T_out     (T_out),
        .X_out     (X_out),
        .Y_out     (Y_out),
        .V_in      (V_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_col   (pix_col),
        .pix_row   (pix_row),
        .pix_last  (pix_last),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Echo generator: X^Y delayed LAT ena-qualified cycles.
    initial begin
        for (int i = 0; i < LAT; i++) gen_pipe[i] = '0;
    end

    always @(posedge clk) begin
        if (ena_out) begin
            gen_pipe[0] <= X_out ^ Y_out;
            for (int i = 1; i < LAT; i++) gen_pipe[i] <= gen_pipe[i-1];
        end
    end

    assign V_in = gen_pipe[LAT-1];

    // Sink readiness: constant high or a coin flip per cycle.
    always @(posedge clk) begin
        #1;
        pix_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: handshake rules, hold stability, scoreboard compare, timing.
    logic        hold_prev = 0;
    logic        prev_fd = 0;
    logic [31:0] h_data;
    logic [11:0] h_col, h_row;
    logic        h_last;

    always @(negedge clk) begin
        pix_t e;
        if (mon_en) begin
            checkOutput("ena_out", 32'(ena_out), 32'(!pix_valid || pix_ready));
            if (hold_prev) begin
                checkOutput("hold_valid", 32'(pix_valid), 32'd1);
                checkOutput("hold_data", pix_data, h_data);
                checkOutput("hold_col", 32'(pix_col), 32'(h_col));
                checkOutput("hold_row", 32'(pix_row), 32'(h_row));
                checkOutput("hold_last", 32'(pix_last), 32'(h_last));
            end
            if (first_check && pix_valid) begin
                checkOutput("first_latency", cyc, exp_first_cyc);
                first_check = 0;
            end
            if (pix_valid && pix_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_pixel: got col %0d row %0d, expected none", pix_col, pix_row);
                end else begin
                    e = sb.pop_front();
                    checkOutput("pix_data", pix_data, e.data);
                    checkOutput("pix_col", 32'(pix_col), 32'(e.col));
                    checkOutput("pix_row", 32'(pix_row), 32'(e.row));
                    checkOutput("pix_last", 32'(pix_last), 32'(e.last));
                    if (!rand_mode && !e.first) checkOutput("throughput_gap", cyc - last_acc_cyc, 32'd1);
                    last_acc_cyc = cyc;
                    if (e.last) last_final_cyc = cyc;
                end
            end
            if (frame_done) begin
                checkOutput("frame_done_delay", cyc - last_final_cyc, 32'd1);
                checkOutput("frame_done_width", 32'(prev_fd), 32'd0);
            end
        end
        prev_fd   = frame_done;
        hold_prev = pix_valid && !pix_ready;
        h_data    = pix_data;
        h_col     = pix_col;
        h_row     = pix_row;
        h_last    = pix_last;
    end

    task automatic checkReset();
        checkOutput("rst_T", T_out, 32'h0);
        checkOutput("rst_X", X_out, 32'hFFFF_0000);
        checkOutput("rst_Y", Y_out, 32'hFFFF_0000);
        checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
        checkOutput("rst_pix_data", pix_data, 32'h0);
        checkOutput("rst_pix_col", 32'(pix_col), 32'd0);
        checkOutput("rst_pix_row", 32'(pix_row), 32'd0);
        checkOutput("rst_pix_last", 32'(pix_last), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic resetDut();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        first_check = 0;
        mon_en = 1;
        checkReset();
    endtask

    // Queue the expected stream for nframes and pulse start.
    task automatic applyStimulus(input int nframes, input bit cont_v, input bit rand_v);
        pix_t p;
        for (int f = 0; f < nframes; f++) begin
            for (int i = 0; i < 8; i++) begin
                p.data  = exp_data[i];
                p.col   = 12'(i % 4);
                p.row   = 12'(i / 4);
                p.last  = (i == 7);
                p.first = (i == 0);
                sb.push_back(p);
            end
        end
        rand_mode     = rand_v;
        cont          = cont_v;
        exp_first_cyc = cyc + 2 + LAT;
        first_check   = 1;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitFrameDone(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_done && k < 400);
        if (!frame_done) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: got no frame_done, expected one within 400 cycles", name);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        $display("[TB] reset check");
        resetDut();

        $display("[TB] single frame, ready high");
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("scan_busy", 32'(busy), 32'd1);
        checkOutput("scan_X0", X_out, 32'hFFFF_0000);
        waitFrameDone("f1");
        checkOutput("f1_T", T_out, 32'h400);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("f1_idle", 32'(busy), 32'd0);

        $display("[TB] single frame, random ready");
        applyStimulus(1, 1'b0, 1'b1);
        waitFrameDone("f2");
        checkOutput("f2_T", T_out, 32'h800);
        rand_mode = 0;
        repeat (3) @(posedge clk);

        $display("[TB] three continuous frames");
        resetDut();
        applyStimulus(3, 1'b1, 1'b0);
        waitFrameDone("c1");
        checkOutput("c1_T", T_out, 32'h400);
        checkOutput("c1_nogap_busy", 32'(busy), 32'd1);
        checkOutput("c1_nogap_X", X_out, 32'hFFFF_0000);
        checkOutput("c1_nogap_Y", Y_out, 32'hFFFF_0000);
        waitFrameDone("c2");
        checkOutput("c2_T", T_out, 32'h800);
        cont = 1'b0;
        waitFrameDone("c3");
        checkOutput("c3_T", T_out, 32'hC00);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("c3_idle", 32'(busy), 32'd0);

        $display("[TB] reset in the middle of a scan");
        applyStimulus(1, 1'b0, 1'b0);
        begin
            int k = 0;
            while (!(X_out == 32'h0 && Y_out == 32'h0) && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            checkOutput("midscan_reached", 32'(X_out == 32'h0 && Y_out == 32'h0), 32'd1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        first_check = 0;
        checkReset();
        repeat (40) @(posedge clk);
        #1;
        checkOutput("midscan_idle", 32'(busy), 32'd0);
        applyStimulus(1, 1'b0, 1'b0);
        waitFrameDone("after_rst");
        checkOutput("after_rst_T", T_out, 32'h400);

`ifdef IBNIZ_SCAN_PAUSE_EN
        $display("[TB] paused time base over two frames");
        resetDut();
        pause = 1'b1;
        applyStimulus(2, 1'b1, 1'b0);
        waitFrameDone("p1");
        checkOutput("p1_T", T_out, 32'h0);
        cont = 1'b0;
        waitFrameDone("p2");
        checkOutput("p2_T", T_out, 32'h0);
        pause = 1'b0;
`endif

        repeat (5) @(posedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
